// File: rtl/mmu_host_if.sv
// Host-side adapter for the 2x2 systolic matrix-multiply unit.
// Collects eight operand bytes (A then B, row-major) from a valid/ready stream and pulses
// mmu_start. It then waits for mmu_done under a watchdog and streams the four captured
// C bytes back to the host.
module mmu_host_if #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 mmu_start,
    output logic [1:0][1:0][7:0] mmu_a,
    output logic [1:0][1:0][7:0] mmu_b,
    input  logic [1:0][1:0][7:0] mmu_c,
    input  logic                 mmu_done,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        StLoad,
        StStart,
        StWait,
        StDrain
    } state_e;

    // Last WAIT count value before the watchdog fires.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e               r_state, w_state_next;
    logic [2:0]           r_idx, w_idx_next;
    logic [7:0]           r_cnt, w_cnt_next;
    logic [1:0][1:0][7:0] r_a, w_a_next;
    logic [1:0][1:0][7:0] r_b, w_b_next;
    logic [1:0][1:0][7:0] r_c, w_c_next;
    logic                 r_start, w_start_next;
    logic                 r_out_valid, w_out_valid_next;
    logic [7:0]           r_out_data, w_out_data_next;
    logic                 r_err, w_err_next;
    logic [1:0]           w_drain_nxt;

    assign in_ready    = (r_state == StLoad);
    assign busy        = (r_state != StLoad);
    assign mmu_start   = r_start;
    assign mmu_a       = r_a;
    assign mmu_b       = r_b;
    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign timeout_err = r_err;
    assign w_drain_nxt = r_idx[1:0] + 2'd1;

    // Next-state and registered-output logic for the load/start/wait/drain sequence.
    always_comb begin
        w_state_next     = r_state;
        w_idx_next       = r_idx;
        w_cnt_next       = r_cnt;
        w_a_next         = r_a;
        w_b_next         = r_b;
        w_c_next         = r_c;
        w_start_next     = 1'b0;
        w_out_valid_next = r_out_valid;
        w_out_data_next  = r_out_data;
        w_err_next       = r_err;

        unique case (r_state)
            StLoad: begin
                if (in_valid) begin
                    // A new job starting clears any previous watchdog error.
                    if (r_idx == 3'd0) begin
                        w_err_next = 1'b0;
                    end
                    if (!r_idx[2]) begin
                        w_a_next[r_idx[1]][r_idx[0]] = in_data;
                    end else begin
                        w_b_next[r_idx[1]][r_idx[0]] = in_data;
                    end
                    if (r_idx == 3'd7) begin
                        w_idx_next   = 3'd0;
                        w_start_next = 1'b1;
                        w_state_next = StStart;
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
            StStart: begin
                w_cnt_next   = 8'd0;
                w_state_next = StWait;
            end
            StWait: begin
                // done takes priority over a coincident watchdog expiry.
                if (mmu_done) begin
                    w_c_next         = mmu_c;
                    w_idx_next       = 3'd0;
                    w_out_valid_next = 1'b1;
                    w_out_data_next  = mmu_c[0][0];
                    w_state_next     = StDrain;
                end else if (r_cnt == CntLast) begin
                    w_err_next   = 1'b1;
                    w_idx_next   = 3'd0;
                    w_cnt_next   = 8'd0;
                    w_state_next = StLoad;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            StDrain: begin
                if (r_out_valid && out_ready) begin
                    if (r_idx[1:0] == 2'd3) begin
                        w_out_valid_next = 1'b0;
                        w_out_data_next  = 8'd0;
                        w_idx_next       = 3'd0;
                        w_state_next     = StLoad;
                    end else begin
                        w_idx_next      = r_idx + 3'd1;
                        w_out_data_next = r_c[w_drain_nxt[1]][w_drain_nxt[0]];
                    end
                end
            end
            default: begin
                w_state_next = StLoad;
            end
        endcase
    end

    // State and datapath registers; reset aborts any job in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StLoad;
            r_idx       <= 3'd0;
            r_cnt       <= 8'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_start     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_cnt       <= w_cnt_next;
            r_a         <= w_a_next;
            r_b         <= w_b_next;
            r_c         <= w_c_next;
            r_start     <= w_start_next;
            r_out_valid <= w_out_valid_next;
            r_out_data  <= w_out_data_next;
            r_err       <= w_err_next;
        end
    end

endmodule

// File: tb/tb_mmu_host_if.sv
// Self-checking bench for mmu_host_if: the bench plays the MMU and the host. Expected
// results come from a plain 2x2 matrix product with 8-bit saturation.
module tb_mmu_host_if;

    localparam int TIMEOUT = 16;

    logic                 clk;
    logic                 rst;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 mmu_start;
    logic [1:0][1:0][7:0] mmu_a;
    logic [1:0][1:0][7:0] mmu_b;
    logic [1:0][1:0][7:0] mmu_c;
    logic                 mmu_done;
    logic                 busy;
    logic                 timeout_err;

    int         n_vec;
    int         n_err;
    int         start_cnt;
    logic [7:0] job_bytes [8];

    mmu_host_if #(
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mmu_start  (mmu_start),
        .mmu_a      (mmu_a),
        .mmu_b      (mmu_b),
        .mmu_c      (mmu_c),
        .mmu_done   (mmu_done),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count start pulses, one sample per cycle.
    always @(negedge clk) begin
        if (mmu_start) start_cnt = start_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: C = A x B, A row-major in bytes 0..3, B in bytes 4..7, saturated to 255.
    function automatic logic [7:0] exp_c(input int i, input int j);
        int s;
        s = int'(job_bytes[2*i]) * int'(job_bytes[4+j])
          + int'(job_bytes[2*i+1]) * int'(job_bytes[6+j]);
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    // gap_mode: 0 back-to-back, 1 alternating valid, 2 random valid.
    task automatic send_job(input int gap_mode);
        int i;
        int n;
        bit tog;
        bit v;
        bit acc;
        i   = 0;
        n   = 0;
        tog = 1'b1;
        while (i < 8 && n < 200) begin
            @(negedge clk);
            v        = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog      = !tog;
            in_valid = v;
            in_data  = v ? job_bytes[i] : 8'($urandom);
            acc      = v && in_ready;
            @(posedge clk);
            if (acc) begin
                if (i == 0) begin
                    #1;
                    check_eq("err_clear_on_byte0", 32'(timeout_err), 0);
                end
                i = i + 1;
            end
            n = n + 1;
        end
        if (i < 8) check_eq("load_bound", i, 8);
    endtask

    // done_k: WAIT count at which mmu_done is pulsed; out of range means never.
    task automatic wait_done(input int done_k, output bit drained);
        drained = 1'b0;
        @(negedge clk);
        check_eq("start_pulse", 32'(mmu_start), 1);
        check_eq("in_ready_start", 32'(in_ready), 0);
        check_eq("busy_start", 32'(busy), 1);
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                check_eq("mmu_a", 32'(mmu_a[i][j]), 32'(job_bytes[2*i+j]));
                check_eq("mmu_b", 32'(mmu_b[i][j]), 32'(job_bytes[4+2*i+j]));
            end
        end
        // Garbage on the input stream and a stray done in START must both be ignored.
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        mmu_done = (done_k != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        mmu_c    = $urandom;
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            if (k == 0) check_eq("start_one_cycle", 32'(mmu_start), 0);
            check_eq("no_early_timeout", 32'(timeout_err), 0);
            check_eq("wait_no_out", 32'(out_valid), 0);
            if (k == done_k) begin
                mmu_done = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    for (int j = 0; j < 2; j++) mmu_c[i][j] = exp_c(i, j);
                end
                @(negedge clk);
                mmu_done = 1'b0;
                mmu_c    = $urandom;
                in_valid = 1'b0;
                check_eq("first_out_valid", 32'(out_valid), 1);
                drained = 1'b1;
                break;
            end
            mmu_done = 1'b0;
            mmu_c    = $urandom;
        end
        if (!drained) begin
            @(negedge clk);
            in_valid = 1'b0;
            check_eq("timeout_err_set", 32'(timeout_err), 1);
            check_eq("in_ready_after_to", 32'(in_ready), 1);
            check_eq("busy_after_to", 32'(busy), 0);
        end
    endtask

    // stall_mode: 0 always ready, 1 ten stalled cycles first, 2 random ready.
    task automatic drain(input int stall_mode);
        int got;
        int n;
        got = 0;
        n   = 0;
        while (got < 4 && n < 300) begin
            out_ready = (stall_mode == 0) ? 1'b1 :
                        (stall_mode == 1) ? (n >= 10) : 1'($urandom_range(0, 1));
            check_eq("out_valid", 32'(out_valid), 1);
            check_eq("out_data", 32'(out_data), 32'(exp_c(got / 2, got % 2)));
            @(posedge clk);
            if (out_ready) got = got + 1;
            n = n + 1;
            @(negedge clk);
        end
        if (got < 4) check_eq("drain_bound", got, 4);
        out_ready = 1'b0;
        check_eq("out_valid_dropped", 32'(out_valid), 0);
        check_eq("busy_after_drain", 32'(busy), 0);
        check_eq("in_ready_after_drain", 32'(in_ready), 1);
        check_eq("no_err_after_drain", 32'(timeout_err), 0);
    endtask

    task automatic run_job(input int gap_mode, input int stall_mode, input int done_k);
        int s0;
        bit drained;
        s0 = start_cnt;
        send_job(gap_mode);
        wait_done(done_k, drained);
        if (drained) drain(stall_mode);
        check_eq("one_start_per_job", start_cnt - s0, 1);
    endtask

    task automatic check_idle_zero(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 1);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_start"}, 32'(mmu_start), 0);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_out_data"}, 32'(out_data), 0);
        check_eq({tag, "_timeout_err"}, 32'(timeout_err), 0);
        check_eq({tag, "_mmu_a"}, mmu_a, 0);
        check_eq({tag, "_mmu_b"}, mmu_b, 0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        start_cnt = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        out_ready = 1'b0;
        mmu_done  = 1'b0;
        mmu_c     = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        // 1..8 -> 19, 22, 43, 50.
        for (int i = 0; i < 8; i++) job_bytes[i] = 8'(i + 1);
        run_job(0, 0, 2);

        // Saturation passthrough.
        for (int i = 0; i < 8; i++) job_bytes[i] = 8'd16;
        run_job(0, 0, 0);

        // Alternating valid and a ten-cycle output stall.
        for (int i = 0; i < 8; i++) job_bytes[i] = 8'(i + 1);
        run_job(1, 1, 4);

        // Watchdog expiry, then a job that clears it on byte 0.
        run_job(0, 0, -1);
        run_job(2, 2, 1);

        // done on the exact timeout cycle wins.
        run_job(0, 0, TIMEOUT - 1);

        // Reset mid-WAIT aborts the job; a following job runs normally.
        for (int i = 0; i < 8; i++) job_bytes[i] = 8'($urandom);
        send_job(0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_idle_zero("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) job_bytes[i] = 8'(i + 1);
        run_job(0, 0, 3);

        // Randomized jobs, a few of which deliberately time out.
        for (int t = 0; t < 24; t++) begin
            for (int i = 0; i < 8; i++) begin
                job_bytes[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255))
                                                           : 8'($urandom_range(0, 12));
            end
            run_job(2, 2, int'($urandom_range(0, 19)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
